// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM input and measurement results bundled between a PWM source/consumer and pwm_capture.
interface pwm_capture_if #(
   parameter int CNT_W = 16
);
   logic             pwm_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             stuck_high;
   logic             stuck_low;
   modport master (output pwm_in, input period, high_time, meas_valid, locked, stuck_high, stuck_low);
   modport slave  (input pwm_in, output period, high_time, meas_valid, locked, stuck_high, stuck_low);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input and flags stuck (edgeless) inputs.
// Optional run-length glitch filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture #(
   parameter int CNT_W      = 16,
   parameter int FILTER_LEN = 4
) (
   input logic          clk,
   input logic          rst,
   pwm_capture_if.slave bus
);
   typedef enum logic {IDLE, MEAS} state_t;
   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   if (FILTER_LEN < 2 || FILTER_LEN > 16) begin : g_bad_filter_len
      $error("pwm_capture: FILTER_LEN must be in 2..16");
   end
   state_t           state_q, state_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, level, rise;
   logic             to_q, to_d, timeout;
   logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
   logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
   logic             valid_q, valid_d, locked_q, locked_d, sh_q, sh_d, sl_q, sl_d;
`ifdef PWM_CAP_FILTER_EN
   logic       filt_q, filt_d;
   logic [4:0] fcnt_q, fcnt_d;
   // Level only follows the synchroniser after FILTER_LEN consecutive differing samples.
   always_comb begin
      fcnt_d = (sync2_q == filt_q) ? 5'd0 : fcnt_q + 5'd1;
      filt_d = filt_q;
      if (sync2_q != filt_q && fcnt_q == 5'(FILTER_LEN - 1)) begin
         filt_d = sync2_q;
         fcnt_d = 5'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
      end
   end
   assign level = filt_q;
`else
   assign level = sync2_q;
`endif
   always_comb begin
      sync1_d  = bus.pwm_in;
      sync2_d  = sync1_q;
      prev_d   = level;
      rise     = level & ~prev_q;
      pcnt_d   = rise ? ONE : (pcnt_q == MAX ? MAX : pcnt_q + ONE);
      hcnt_d   = rise ? ONE : (level && hcnt_q != MAX ? hcnt_q + ONE : hcnt_q);
      // to_q marks that this saturation was already reported, so flags fire once per stall.
      timeout  = pcnt_q == MAX && !rise && !to_q;
      to_d     = rise ? 1'b0 : (timeout | to_q);
      state_d  = state_q;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      sh_d     = sh_q;
      sl_d     = sl_q;
      if (rise) begin
         state_d = MEAS;
         sh_d    = 1'b0;
         sl_d    = 1'b0;
         if (state_q == MEAS) begin
            period_d = pcnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
         end
      end else if (timeout) begin
         state_d  = IDLE;
         locked_d = 1'b0;
         sh_d     = level;
         sl_d     = ~level;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         to_q     <= 1'b0;
         pcnt_q   <= '0;
         hcnt_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         sh_q     <= 1'b0;
         sl_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         prev_q   <= prev_d;
         to_q     <= to_d;
         pcnt_q   <= pcnt_d;
         hcnt_q   <= hcnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         sh_q     <= sh_d;
         sl_q     <= sl_d;
      end
   end
   assign bus.period     = period_q;
   assign bus.high_time  = high_q;
   assign bus.meas_valid = valid_q;
   assign bus.locked     = locked_q;
   assign bus.stuck_high = sh_q;
   assign bus.stuck_low  = sl_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture at CNT_W=16 and CNT_W=8 (filter glitch case when PWM_CAP_FILTER_EN is defined).
module tb_pwm_capture;
`ifdef PWM_CAP_FILTER_EN
   localparam int LAT = 2 + 4;
`else
   localparam int LAT = 2;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   int   nchk = 0;
   int   nerr = 0;
   pwm_capture_if #(.CNT_W(16)) b16 ();
   pwm_capture_if #(.CNT_W(8))  b8 ();
   pwm_capture #(.CNT_W(16), .FILTER_LEN(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
   pwm_capture #(.CNT_W(8),  .FILTER_LEN(4)) dut8  (.clk(clk), .rst(rst), .bus(b8));
   always #5 clk = ~clk;
   logic [15:0] o_per, o_hi;
   logic        o_vld, o_lck, o_sh, o_sl;
   assign o_per = sel ? {8'd0, b8.period}    : b16.period;
   assign o_hi  = sel ? {8'd0, b8.high_time} : b16.high_time;
   assign o_vld = sel ? b8.meas_valid : b16.meas_valid;
   assign o_lck = sel ? b8.locked     : b16.locked;
   assign o_sh  = sel ? b8.stuck_high : b16.stuck_high;
   assign o_sl  = sel ? b8.stuck_low  : b16.stuck_low;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic chk_reset();
      chk("rst_period", o_per, 16'd0);
      chk("rst_high", o_hi, 16'd0);
      chk("rst_valid", 16'(o_vld), 16'd0);
      chk("rst_locked", 16'(o_lck), 16'd0);
      chk("rst_stuck_high", 16'(o_sh), 16'd0);
      chk("rst_stuck_low", 16'(o_sl), 16'd0);
   endtask
   // One PWM period starting with a rise; ev/ep/eh give the report expected from that rise.
   task automatic pwm(input int hi, input int per, input bit g, input bit ev, input int ep, input int eh);
      logic v;
      for (int i = 0; i < per; i++) begin
         v = (i < hi) || (g && (i == 200 || i == 201));
         if (sel) b8.pwm_in = v; else b16.pwm_in = v;
         tick();
         if (i == LAT - 1) chk("valid_early", 16'(o_vld), 16'd0);
         if (i == LAT) begin
            chk("valid", 16'(o_vld), 16'(ev));
            chk("locked", 16'(o_lck), 16'(ev));
            chk("stuck_high_rise", 16'(o_sh), 16'd0);
            chk("stuck_low_rise", 16'(o_sl), 16'd0);
            if (ev) begin
               chk("period", o_per, 16'(ep));
               chk("high_time", o_hi, 16'(eh));
            end
         end
         if (i == LAT + 1) chk("valid_pulse", 16'(o_vld), 16'd0);
      end
   endtask
   initial begin
      b16.pwm_in = 1'b0;
      b8.pwm_in  = 1'b0;
      repeat (3) tick();
      chk_reset();
      rst = 1'b0;
      pwm(50, 500, 0, 0, 0, 0);
      pwm(50, 500, 0, 1, 500, 50);
      pwm(50, 500, 0, 1, 500, 50);
`ifdef PWM_CAP_FILTER_EN
      pwm(50, 500, 1, 1, 500, 50);
      pwm(50, 500, 0, 1, 500, 50);
`endif
      pwm(150, 200, 0, 1, 500, 50);
      pwm(150, 200, 0, 1, 200, 150);
      pwm(50, 250, 0, 1, 200, 150);
      rst = 1'b1;
      tick();
      chk_reset();
      rst = 1'b0;
      pwm(50, 500, 0, 0, 0, 0);
      pwm(50, 500, 0, 1, 500, 50);
      sel = 1'b1;
      b8.pwm_in = 1'b1;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (LAT + 255) tick();
      chk("stuck_high_before_sat", 16'(o_sh), 16'd0);
      tick();
      chk("stuck_high_at_sat", 16'(o_sh), 16'd1);
      chk("stuck_low_at_sat", 16'(o_sl), 16'd0);
      chk("locked_at_sat", 16'(o_lck), 16'd0);
      chk("valid_at_sat", 16'(o_vld), 16'd0);
      b8.pwm_in = 1'b0;
      repeat (10) tick();
      chk("stuck_high_held", 16'(o_sh), 16'd1);
      chk("stuck_low_held", 16'(o_sl), 16'd0);
      pwm(30, 100, 0, 0, 0, 0);
      pwm(30, 100, 0, 1, 100, 30);
      pwm(30, 255, 0, 1, 100, 30);
      pwm(30, 255, 0, 1, 255, 30);
      pwm(30, 255, 0, 1, 255, 30);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM capture block: measures period and high time of an external PWM signal, in `clk` cycles. It is the receive-side counterpart of the team's PWM generators, used for loopback self-test and for decoding PWM from off-board sensors. `pwm_in` is asynchronous and is synchronised internally. Results are published as a one-cycle valid pulse with held registers; a stuck (edgeless) input is detected and flagged.

## Interface
- `CNT_W`, 16, width of the period/high-time counters; the saturation value is 2^CNT_W-1.
- `FILTER_LEN`, 4, glitch-filter length in cycles; used only when `PWM_CAP_FILTER_EN` is defined; range 2..16.

- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `pwm_in`  input  1  asynchronous PWM input.
- `period`  output  CNT_W  cycles between the last two rising edges; reset value 0.
- `high_time`  output  CNT_W  high cycles in the last complete period; reset value 0.
- `meas_valid`  output  1  one-cycle pulse when `period`/`high_time` update; reset value 0.
- `locked`  output  1  at least one full period has been measured since reset or timeout; reset value 0.
- `stuck_high`  output  1  timeout occurred with the input at 1; reset value 0.
- `stuck_low`  output  1  timeout occurred with the input at 0; reset value 0.

## Operation
- Input path: 2-flop synchroniser, then the optional filter, then a `prev` register.
  - `rise` = level & ~prev.
  - `fall` = ~level & prev.
- Period counter `pcnt`:
  - On `rise`: `pcnt` <= 1.
  - Otherwise: `pcnt` <= `pcnt`+1, saturating at 2^CNT_W-1.
- High counter `hcnt`:
  - On `rise`: `hcnt` <= 1.
  - Otherwise it increments (saturating) while level=1, and holds while level=0.
- State machine has two states, IDLE and MEAS. Reset enters IDLE.
- IDLE:
  - First `rise` moves to MEAS.
  - No `meas_valid` is generated in IDLE.
  - `stuck_*` clear on that `rise`.
- MEAS, on each `rise`:
  - `period` <= `pcnt` and `high_time` <= `hcnt`, using the values before they restart.
  - `meas_valid` pulses and `locked` sets.
- Timeout (either state): when `pcnt` reaches 2^CNT_W-1 with no `rise` in the same cycle:
  - Return to IDLE and clear `locked`.
  - Set `stuck_high` if level=1, else `stuck_low`.
  - `period`/`high_time` hold their last values.
  - Counting continues saturated, so no repeated flag toggling.
- Simultaneous `rise` and saturation: `rise` wins; the measurement is taken with `period` = 2^CNT_W-1 and no timeout occurs.
- 0% / 100% duty yields no edges and is reported only via `stuck_low` / `stuck_high`.
- Reset mid-measurement: all outputs return to their reset values next cycle; the partial period is discarded; two further rises are required before `meas_valid`.

## Timing
- Without the filter, `meas_valid` is high in the cycle starting 3 clk edges after the edge on which `pwm_in` is first sampled high: sync1, sync2, then output register.
- `period`/`high_time` change in the same cycle as `meas_valid` and are stable until the next pulse.
- Measurement is exact for a clean synchronous input. Example: a 500-cycle period with 50 high cycles gives `period`=500 and `high_time`=50.
- An asynchronous input carries ±1 cycle of quantisation.
- `stuck_*` assert in the cycle after `pcnt` saturates; `locked` deasserts in that same cycle.
- Minimum measurable high or low time is 1 cycle without the filter.

## Configuration
- `PWM_CAP_FILTER_EN` defined:
  - A majority-free run-length filter sits after the synchroniser.
  - The filtered level changes only after FILTER_LEN consecutive equal synchronised samples.
  - Pulses shorter than FILTER_LEN cycles are ignored.
  - All latencies grow by FILTER_LEN cycles.
  - Measured period and high time are unchanged for clean pulses of at least FILTER_LEN cycles.
  - The filter resets to level 0.
- `PWM_CAP_FILTER_EN` not defined: no filter, FILTER_LEN is unused, and latency is as stated in Timing.

## Test plan
- Synchronous 500/50 PWM after reset:
  - First `meas_valid` on the second rise.
  - Then `period`=500 and `high_time`=50, with `meas_valid` every 500 cycles.
  - `locked`=1 after the first `meas_valid`.
- Period change from 500/50 to 200/150 on a period boundary: the next `meas_valid` reports 200/150 with no intermediate corrupt value.
- CNT_W=8, input held high after reset: `stuck_high`=1 exactly after `pcnt` saturates at 255; `locked`=0. Then apply a 100/30 PWM: `stuck_high` clears on the first rise, and 100/30 is reported on the second rise.
- Assert `rst` for 1 cycle halfway through a 500/50 stream: all outputs go to 0 the next cycle, and the next valid report is 500/50 after two further rises.
- `PWM_CAP_FILTER_EN` with FILTER_LEN=4, 500/50 input with a 2-cycle high glitch in the low phase: the glitch is rejected, the report is 500/50, and latency is 7 cycles.
- Simultaneous event: with CNT_W=8, place a rise exactly when `pcnt` hits 255: `meas_valid` with `period`=255, and no `stuck_*` flag.
